// File: rtl/rad_minmax_scan_pkg.sv
// Shared HDR package: scan-state encoding and default datapath widths
// used by the radiance min/max scan and the tone stage.
package rad_minmax_scan_pkg;

  localparam int HDR_D_W    = 16;
  localparam int HDR_ADDR_W = 16;
  localparam int HDR_NUM_W  = 17;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_FIN   = 2'd3
  } scan_state_e;

endpackage

// File: rtl/rad_minmax_scan_if.sv
// Scan control, radiance buffer read port and result bus.
// The scanner sits on the slave side.
interface rad_minmax_scan_if
  import rad_minmax_scan_pkg::*;
#(
  parameter int D_W    = HDR_D_W,
  parameter int ADDR_W = HDR_ADDR_W,
  parameter int NUM_W  = HDR_NUM_W
);
  logic              start;
  logic [NUM_W-1:0]  total_pixels;
  logic [ADDR_W-1:0] addr;
  logic              ren;
  logic [D_W-1:0]    rdata;
  logic [D_W-1:0]    rad_min;
  logic [D_W-1:0]    rad_maxmin;
  logic              busy;
  logic              fin;

  modport master (
    output start, total_pixels, rdata,
    input  addr, ren, rad_min, rad_maxmin, busy, fin
  );

  modport slave (
    input  start, total_pixels, rdata,
    output addr, ren, rad_min, rad_maxmin, busy, fin
  );
endinterface

// File: rtl/rad_minmax_scan_minmax_acc.sv
// Running min/max register pair. min_nxt/max_nxt expose the post-compare
// values so the owner can capture a result on the same edge as the last sample.
module minmax_acc
  import rad_minmax_scan_pkg::*;
#(
  parameter int D_W = HDR_D_W
) (
  input  logic           i_clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           vld,
  input  logic [D_W-1:0] data,
  output logic [D_W-1:0] min_nxt,
  output logic [D_W-1:0] max_nxt
);
  logic [D_W-1:0] min_q, max_q;

  always_comb begin
    min_nxt = min_q;
    max_nxt = max_q;
    if (vld) begin
      if (data < min_q) min_nxt = data;
      if (data > max_q) max_nxt = data;
    end
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      min_q <= '1;
      max_q <= '0;
    end else if (clr) begin
      min_q <= '1;
      max_q <= '0;
    end else begin
      min_q <= min_nxt;
      max_q <= max_nxt;
    end
  end
endmodule

// File: rtl/rad_minmax_scan.sv
// Streams N radiance samples out of the buffer and reports min and
// (max - min, floored at 1) for the tone-mapping stage.
module rad_minmax_scan
  import rad_minmax_scan_pkg::*;
#(
  parameter int D_W    = HDR_D_W,
  parameter int ADDR_W = HDR_ADDR_W,
  parameter int NUM_W  = HDR_NUM_W
) (
  input logic              i_clk,
  input logic              rst_n,
  rad_minmax_scan_if.slave bus
);
  scan_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [NUM_W-1:0]  left_q, left_d;
  logic              ren_q, ren_d;
  logic              vld_pipe;
  logic [D_W-1:0]    rad_min_q, rad_min_d;
  logic [D_W-1:0]    span_q, span_d;
  logic [D_W-1:0]    acc_min, acc_max, diff;
  logic              clr;

  minmax_acc #(.D_W(D_W)) u_acc (
    .i_clk   (i_clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .vld     (vld_pipe),
    .data    (bus.rdata),
    .min_nxt (acc_min),
    .max_nxt (acc_max)
  );

  assign diff = acc_max - acc_min;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    left_d    = left_q;
    ren_d     = ren_q;
    rad_min_d = rad_min_q;
    span_d    = span_q;
    clr       = 1'b0;
    case (state_q)
      S_IDLE, S_FIN: begin
        if (bus.start) begin
          if (bus.total_pixels == '0) begin
            // Empty scan: publish the neutral result without touching the buffer.
            rad_min_d = '0;
            span_d    = D_W'(1);
            state_d   = S_FIN;
          end else begin
            left_d  = bus.total_pixels - 1'b1;
            addr_d  = '0;
            ren_d   = 1'b1;
            clr     = 1'b1;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (left_q == '0) begin
          ren_d   = 1'b0;
          state_d = S_DRAIN;
        end else begin
          left_d = left_q - 1'b1;
          addr_d = addr_q + 1'b1;
        end
      end
      S_DRAIN: begin
        // Last sample lands this cycle; capture the post-compare values directly.
        rad_min_d = acc_min;
        span_d    = (diff == '0) ? D_W'(1) : diff;
        state_d   = S_FIN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      left_q    <= '0;
      ren_q     <= 1'b0;
      vld_pipe  <= 1'b0;
      rad_min_q <= '0;
      span_q    <= D_W'(1);
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      left_q    <= left_d;
      ren_q     <= ren_d;
      vld_pipe  <= ren_q;
      rad_min_q <= rad_min_d;
      span_q    <= span_d;
    end
  end

  assign bus.addr       = addr_q;
  assign bus.ren        = ren_q;
  assign bus.rad_min    = rad_min_q;
  assign bus.rad_maxmin = span_q;
  assign bus.busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign bus.fin        = (state_q == S_FIN);
endmodule
